// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequential restoring divider controller (IDLE -> CALC -> DONE).
// One quotient bit is resolved per CALC cycle, so an operation takes N
// iterations. Every output is driven from a register.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations
// and goes straight to DONE with quotient = all ones and remainder = dividend.
module div_seq_ctrl #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_by_zero,
   output logic         busy
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_r, state_s;
   // The partial remainder is always below D after a step, so N bits hold it;
   // the extra carry bit of the N+1-bit working remainder exists only in trial_s.
   logic [N-1:0]   rem_r, rem_s;
   logic [N-1:0]   q_r, q_s;
   logic [N-1:0]   d_r, d_s;
   logic [CW-1:0]  cnt_r, cnt_s;
   logic [N-1:0]   quot_s, remo_s;
   logic           dbz_s;
   logic           req_ready_s, resp_valid_s, busy_s;
   logic [N:0]     trial_s;
   logic [N-1:0]   diff_s;
   logic           take_s;

   // Trial subtraction for the current iteration: shift in next dividend bit and compare with D.
   always_comb begin
      trial_s = {rem_r, q_r[N-1]};
      take_s  = (trial_s >= {1'b0, d_r});
      // When take_s is set the true difference fits in N bits, so the low bits are exact.
      diff_s  = trial_s[N-1:0] - d_r;
   end

   // Next-state, datapath and next-output logic.
   always_comb begin
      state_s = state_r;
      rem_s   = rem_r;
      q_s     = q_r;
      d_s     = d_r;
      cnt_s   = cnt_r;
      quot_s  = quotient;
      remo_s  = remainder;
      dbz_s   = div_by_zero;
      case (state_r)
         IDLE: begin
            if (req_valid && req_ready) begin
               q_s   = dividend;
               d_s   = divisor;
               rem_s = {N{1'b0}};
               cnt_s = {CW{1'b0}};
               dbz_s = (divisor == {N{1'b0}});
`ifdef DIV_ZERO_FAST_EN
               if (divisor == {N{1'b0}}) begin
                  q_s     = {N{1'b1}};
                  rem_s   = dividend;
                  quot_s  = {N{1'b1}};
                  remo_s  = dividend;
                  state_s = DONE;
               end else begin
                  state_s = CALC;
               end
`else
               state_s = CALC;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (take_s) begin
               rem_s = diff_s;
               q_s   = {q_r[N-2:0], 1'b1};
            end else begin
               rem_s = trial_s[N-1:0];
               q_s   = {q_r[N-2:0], 1'b0};
            end
            if (cnt_r == CW'(N - 1)) begin
               state_s = DONE;
               quot_s  = q_s;
               remo_s  = rem_s;
            end else begin
               cnt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
               state_s = CALC;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      req_ready_s  = (state_s == IDLE);
      resp_valid_s = (state_s == DONE);
      busy_s       = (state_s != IDLE);
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         rem_r       <= {N{1'b0}};
         q_r         <= {N{1'b0}};
         d_r         <= {N{1'b0}};
         cnt_r       <= {CW{1'b0}};
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         busy        <= 1'b0;
         quotient    <= {N{1'b0}};
         remainder   <= {N{1'b0}};
         div_by_zero <= 1'b0;
      end else begin
         state_r     <= state_s;
         rem_r       <= rem_s;
         q_r         <= q_s;
         d_r         <= d_s;
         cnt_r       <= cnt_s;
         req_ready   <= req_ready_s;
         resp_valid  <= resp_valid_s;
         busy        <= busy_s;
         quotient    <= quot_s;
         remainder   <= remo_s;
         div_by_zero <= dbz_s;
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (N=16): vector table, corner sequences,
// and random operations checked against plain integer division.
module tb_div_seq_ctrl;

   localparam int N = 16;
`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 17;
`endif

   logic          clk;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [N-1:0]  dividend;
   logic [N-1:0]  divisor;
   logic          resp_valid;
   logic          resp_ready;
   logic [N-1:0]  quotient;
   logic [N-1:0]  remainder;
   logic          div_by_zero;
   logic          busy;

   int checks;
   int failures;

   div_seq_ctrl #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
   } vec_t;

   vec_t vecs[8];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division with the zero-divisor convention.
   function automatic void ref_div(input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] q, output logic [15:0] r,
                                   output logic z);
      if (b == 16'd0) begin
         q = 16'hFFFF;
         r = a;
         z = 1'b1;
      end else begin
         q = a / b;
         r = a % b;
         z = 1'b0;
      end
   endfunction

   // One full operation starting in IDLE; stall = cycles with resp_ready low after resp_valid.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er, input logic ez,
                        input int stall, input string tag);
      int cyc;
      int lat;
      lat        = (b == 16'd0) ? ZLAT : 17;
      resp_ready = (stall == 0);
      req_valid  = 1'b1;
      dividend   = a;
      divisor    = b;
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0;
      dividend  = 16'($urandom);
      divisor   = 16'($urandom);
      cyc = 1;
      while (!resp_valid && cyc < 40) begin
         step();
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(lat));
      check({tag, " quotient"}, 32'(quotient), 32'(eq));
      check({tag, " remainder"}, 32'(remainder), 32'(er));
      check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
      for (int s = 0; s < stall; s++) begin
         step();
         check({tag, " stall valid"}, 32'(resp_valid), 32'd1);
         check({tag, " stall quotient"}, 32'(quotient), 32'(eq));
      end
      resp_ready = 1'b1;
      step();
      check({tag, " ready after resp"}, 32'(req_ready), 32'd1);
      check({tag, " valid after resp"}, 32'(resp_valid), 32'd0);
      check({tag, " held remainder"}, 32'(remainder), 32'(er));
   endtask

   initial begin
      logic [15:0] ra, rb, rq, rr;
      logic        rz;
      logic        seen;
      int          mode;

      checks     = 0;
      failures   = 0;
      rst        = 1'b1;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      dividend   = 16'd0;
      divisor    = 16'd0;

      vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
      vecs[1] = '{16'hFFFF,  16'h0001,  16'hFFFF,  16'h0000,  1'b0};
      vecs[2] = '{16'h1234,  16'hFFFF,  16'h0000,  16'h1234,  1'b0};
      vecs[3] = '{16'h00AB,  16'h0000,  16'hFFFF,  16'h00AB,  1'b1};
      vecs[4] = '{16'h0000,  16'h0005,  16'h0000,  16'h0000,  1'b0};
      vecs[5] = '{16'hFFFF,  16'hFFFF,  16'h0001,  16'h0000,  1'b0};
      vecs[6] = '{16'h0005,  16'h000A,  16'h0000,  16'h0005,  1'b0};
      vecs[7] = '{16'h8000,  16'h0003,  16'h2AAA,  16'h0002,  1'b0};

      // Reset state
      step();
      step();
      check("rst req_ready", 32'(req_ready), 32'd1);
      check("rst resp_valid", 32'(resp_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst quotient", 32'(quotient), 32'd0);
      check("rst remainder", 32'(remainder), 32'd0);
      check("rst div_by_zero", 32'(div_by_zero), 32'd0);
      rst = 1'b0;
      step();

      // Vector table
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 0, $sformatf("vec%0d", i));
      end

      // 100/7 with backpressure in cycles 17-21 and a stray request in cycle 5
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      dividend   = 16'd100;
      divisor    = 16'd7;
      step();
      req_valid = 1'b0;
      check("bp busy c1", 32'(busy), 32'd1);
      check("bp req_ready c1", 32'(req_ready), 32'd0);
      for (int c = 1; c <= 22; c++) begin
         if (c == 5) begin
            req_valid = 1'b1;
            dividend  = 16'd1;
            divisor   = 16'd1;
         end
         if (c == 6) req_valid = 1'b0;
         if (c == 16) check("bp c16 not valid", 32'(resp_valid), 32'd0);
         if (c >= 17) begin
            check($sformatf("bp c%0d valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("bp c%0d quotient", c), 32'(quotient), 32'd14);
            check($sformatf("bp c%0d remainder", c), 32'(remainder), 32'd2);
         end
         if (c == 22) resp_ready = 1'b1;
         step();
      end
      check("bp c23 req_ready", 32'(req_ready), 32'd1);
      check("bp c23 busy", 32'(busy), 32'd0);
      check("bp c23 valid", 32'(resp_valid), 32'd0);
      check("bp c23 quotient held", 32'(quotient), 32'd14);

      // Reset in cycle 8 of 100/7 abandons the operation
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      dividend   = 16'd100;
      divisor    = 16'd7;
      step();
      req_valid = 1'b0;
      for (int c = 1; c < 8; c++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort req_ready", 32'(req_ready), 32'd1);
      check("abort busy", 32'(busy), 32'd0);
      check("abort resp_valid", 32'(resp_valid), 32'd0);
      check("abort quotient", 32'(quotient), 32'd0);
      check("abort remainder", 32'(remainder), 32'd0);
      check("abort div_by_zero", 32'(div_by_zero), 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (resp_valid) seen = 1'b1;
         step();
      end
      check("abort no response", 32'(seen), 32'd0);
      do_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 0, "after abort");

      // Random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         mode = int'($urandom_range(0, 7));
         ra   = 16'($urandom);
         if (mode == 0)      rb = 16'd0;
         else if (mode < 3)  rb = 16'($urandom_range(1, 15));
         else                rb = 16'($urandom);
         ref_div(ra, rb, rq, rr, rz);
         do_op(ra, rb, rq, rr, rz, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
